// File: rtl/game_pkg.sv
// Shared constants and types for the frame compositor: colours, default sprite counts,
// wall bounds and the collision-report FSM state type.
package game_pkg;

  localparam int NUM_BULLETS_DEF = 3;
  localparam int NUM_AST_DEF     = 8;

  localparam logic [11:0] SHIP_COLOR   = 12'hfd0;
  localparam logic [11:0] SCORE_COLOR  = 12'hfff;
  localparam logic [11:0] BULLET_COLOR = 12'h0ff;
  localparam logic [11:0] WALL_COLOR   = 12'hf00;
  localparam logic [11:0] AST_COLOR    = 12'h850;
  localparam logic [11:0] EMPTY_COLOR  = 12'h001;

  localparam logic [9:0] WALL_L_LO = 10'd132;
  localparam logic [9:0] WALL_L_HI = 10'd137;
  localparam logic [9:0] WALL_R_LO = 10'd408;
  localparam logic [9:0] WALL_R_HI = 10'd413;

  typedef enum logic {
    COLL_IDLE    = 1'b0,
    COLL_PENDING = 1'b1
  } coll_state_e;

  function automatic logic in_wall(input logic [9:0] h);
    return ((h >= WALL_L_LO) && (h <= WALL_L_HI)) ||
           ((h >= WALL_R_LO) && (h <= WALL_R_HI));
  endfunction

endpackage

// File: rtl/frame_compositor_if.sv
// Collision report channel between the compositor (master) and game logic (slave).
// COMPOSITOR_WALL_EN adds the wall_hit report bit.
interface frame_compositor_if
  import game_pkg::*;
#(
  parameter int NUM_BULLETS = NUM_BULLETS_DEF,
  parameter int NUM_AST     = NUM_AST_DEF
) ();

  // Handshake: coll_valid stays high until the clock after coll_ack is sampled high;
  // report bits are stable while coll_valid is high, except when a new frame merges in.
  logic                   coll_valid;
  logic                   coll_ack;
  logic                   ship_hit;
  logic [NUM_BULLETS-1:0] bullet_hit;
  logic [NUM_AST-1:0]     ast_hit;
  logic                   coll_overrun;
  coll_state_e            coll_state;
`ifdef COMPOSITOR_WALL_EN
  logic                   wall_hit;
`endif

  modport master (
    output coll_valid, ship_hit, bullet_hit, ast_hit, coll_overrun, coll_state,
`ifdef COMPOSITOR_WALL_EN
    output wall_hit,
`endif
    input  coll_ack
  );

  modport slave (
    input  coll_valid, ship_hit, bullet_hit, ast_hit, coll_overrun, coll_state,
`ifdef COMPOSITOR_WALL_EN
    input  wall_hit,
`endif
    output coll_ack
  );

endinterface

// File: rtl/collision_latch.sv
// Per-frame collision accumulators, end-of-frame snapshot and IDLE/PENDING report FSM.
// COMPOSITOR_WALL_EN adds the ship-vs-wall accumulator.
module collision_latch
  import game_pkg::*;
#(
  parameter int NUM_BULLETS = NUM_BULLETS_DEF,
  parameter int NUM_AST     = NUM_AST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_pixpulse,
  input  logic                   i_frame_end,
  input  logic                   i_hit_ship,
  input  logic [NUM_BULLETS-1:0] i_hit_bullet,
  input  logic [NUM_AST-1:0]     i_hit_ast,
`ifdef COMPOSITOR_WALL_EN
  input  logic                   i_hit_wall,
`endif
  frame_compositor_if.master     coll
);

  coll_state_e            r_state, w_next;
  logic                   w_load, w_merge, w_overrun;
  logic                   r_overrun;
  logic                   r_acc_ship, r_rep_ship;
  logic [NUM_BULLETS-1:0] r_acc_bullet, r_rep_bullet;
  logic [NUM_AST-1:0]     r_acc_ast, r_rep_ast;
`ifdef COMPOSITOR_WALL_EN
  logic                   r_acc_wall, r_rep_wall;
`endif

  // Frame end restarts accumulation; a coincident pixpulse still carries its hit terms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_ship   <= 1'b0;
      r_acc_bullet <= '0;
      r_acc_ast    <= '0;
`ifdef COMPOSITOR_WALL_EN
      r_acc_wall   <= 1'b0;
`endif
    end else if (i_frame_end) begin
      r_acc_ship   <= i_pixpulse & i_hit_ship;
      r_acc_bullet <= {NUM_BULLETS{i_pixpulse}} & i_hit_bullet;
      r_acc_ast    <= {NUM_AST{i_pixpulse}} & i_hit_ast;
`ifdef COMPOSITOR_WALL_EN
      r_acc_wall   <= i_pixpulse & i_hit_wall;
`endif
    end else if (i_pixpulse) begin
      r_acc_ship   <= r_acc_ship | i_hit_ship;
      r_acc_bullet <= r_acc_bullet | i_hit_bullet;
      r_acc_ast    <= r_acc_ast | i_hit_ast;
`ifdef COMPOSITOR_WALL_EN
      r_acc_wall   <= r_acc_wall | i_hit_wall;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= COLL_IDLE;
    else      r_state <= w_next;
  end

  // Ack in the frame-end cycle means the old report was consumed, so the new one replaces it.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_merge   = 1'b0;
    w_overrun = 1'b0;
    case (r_state)
      COLL_IDLE: begin
        if (i_frame_end) begin
          w_next = COLL_PENDING;
          w_load = 1'b1;
        end
      end
      COLL_PENDING: begin
        if (i_frame_end) begin
          if (coll.coll_ack) begin
            w_load = 1'b1;
          end else begin
            w_merge   = 1'b1;
            w_overrun = 1'b1;
          end
        end else if (coll.coll_ack) begin
          w_next = COLL_IDLE;
        end
      end
      default: w_next = COLL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep_ship   <= 1'b0;
      r_rep_bullet <= '0;
      r_rep_ast    <= '0;
`ifdef COMPOSITOR_WALL_EN
      r_rep_wall   <= 1'b0;
`endif
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= w_overrun;
      if (w_load) begin
        r_rep_ship   <= r_acc_ship;
        r_rep_bullet <= r_acc_bullet;
        r_rep_ast    <= r_acc_ast;
`ifdef COMPOSITOR_WALL_EN
        r_rep_wall   <= r_acc_wall;
`endif
      end else if (w_merge) begin
        r_rep_ship   <= r_rep_ship | r_acc_ship;
        r_rep_bullet <= r_rep_bullet | r_acc_bullet;
        r_rep_ast    <= r_rep_ast | r_acc_ast;
`ifdef COMPOSITOR_WALL_EN
        r_rep_wall   <= r_rep_wall | r_acc_wall;
`endif
      end
    end
  end

  assign coll.coll_valid   = (r_state == COLL_PENDING);
  assign coll.coll_state   = r_state;
  assign coll.ship_hit     = r_rep_ship;
  assign coll.bullet_hit   = r_rep_bullet;
  assign coll.ast_hit      = r_rep_ast;
  assign coll.coll_overrun = r_overrun;
`ifdef COMPOSITOR_WALL_EN
  assign coll.wall_hit     = r_rep_wall;
`endif

endmodule

// File: rtl/frame_compositor.sv
// Priority colour mux, blanking and two-stage pixel pipeline feeding the VGA pins,
// plus collision hit terms for collision_latch. COMPOSITOR_WALL_EN enables the walls.
module frame_compositor
  import game_pkg::*;
#(
  parameter int NUM_BULLETS = NUM_BULLETS_DEF,
  parameter int NUM_AST     = NUM_AST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pixpulse,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  input  logic                   hblank,
  input  logic                   vblank,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   draw_ship,
  input  logic                   draw_score,
  input  logic [NUM_BULLETS-1:0] draw_bullet,
  input  logic [NUM_AST-1:0]     draw_ast,
  output logic [3:0]             vgaRed,
  output logic [3:0]             vgaGreen,
  output logic [3:0]             vgaBlue,
  output logic                   hsync,
  output logic                   vsync,
  frame_compositor_if.master     coll
);

  logic                   w_visible, w_any_bullet, w_any_ast, w_in_wall, w_frame_end;
  logic [11:0]            w_color;
  logic                   w_hit_ship;
  logic [NUM_BULLETS-1:0] w_hit_bullet;
  logic [NUM_AST-1:0]     w_hit_ast;
  logic                   w_unused;

  logic [11:0]            r_color, r_rgb;
  logic                   r_vis, r_hs1, r_vs1, r_hs2, r_vs2, r_vblank, r_vblank_q;
  logic                   r_hit_ship;
  logic [NUM_BULLETS-1:0] r_hit_bullet;
  logic [NUM_AST-1:0]     r_hit_ast;
`ifdef COMPOSITOR_WALL_EN
  logic                   w_hit_wall, r_hit_wall;
`endif

  assign w_visible    = ~hblank & ~vblank;
  assign w_any_bullet = |draw_bullet;
  assign w_any_ast    = |draw_ast;
  assign w_in_wall    = in_wall(hcount);
  // vcount is not needed for colour or collision decisions.
  assign w_unused     = ^{vcount, w_in_wall};

  always_comb begin
    w_color = EMPTY_COLOR;
    if (draw_score)        w_color = SCORE_COLOR;
    else if (draw_ship)    w_color = SHIP_COLOR;
    else if (w_any_bullet) w_color = BULLET_COLOR;
    else if (w_any_ast)    w_color = AST_COLOR;
`ifdef COMPOSITOR_WALL_EN
    else if (w_in_wall)    w_color = WALL_COLOR;
`endif
  end

  assign w_hit_ship   = w_visible & draw_ship & w_any_ast;
  assign w_hit_bullet = {NUM_BULLETS{w_visible & w_any_ast}} & draw_bullet;
  assign w_hit_ast    = {NUM_AST{w_visible & (draw_ship | w_any_bullet)}} & draw_ast;
`ifdef COMPOSITOR_WALL_EN
  assign w_hit_wall   = w_visible & draw_ship & w_in_wall;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_color      <= '0;
      r_vis        <= 1'b0;
      r_hs1        <= 1'b1;
      r_vs1        <= 1'b1;
      r_vblank     <= 1'b0;
      r_hit_ship   <= 1'b0;
      r_hit_bullet <= '0;
      r_hit_ast    <= '0;
`ifdef COMPOSITOR_WALL_EN
      r_hit_wall   <= 1'b0;
`endif
      r_rgb        <= '0;
      r_hs2        <= 1'b1;
      r_vs2        <= 1'b1;
    end else if (pixpulse) begin
      r_color      <= w_color;
      r_vis        <= w_visible;
      r_hs1        <= hsync_in;
      r_vs1        <= vsync_in;
      r_vblank     <= vblank;
      r_hit_ship   <= w_hit_ship;
      r_hit_bullet <= w_hit_bullet;
      r_hit_ast    <= w_hit_ast;
`ifdef COMPOSITOR_WALL_EN
      r_hit_wall   <= w_hit_wall;
`endif
      r_rgb        <= r_vis ? r_color : 12'h000;
      r_hs2        <= r_hs1;
      r_vs2        <= r_vs1;
    end
  end

  // Sampled every clk so the frame-end strobe is exactly one clk wide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_vblank_q <= 1'b0;
    else      r_vblank_q <= r_vblank;
  end

  assign w_frame_end = r_vblank & ~r_vblank_q;

  collision_latch #(
    .NUM_BULLETS (NUM_BULLETS),
    .NUM_AST     (NUM_AST)
  ) u_collision_latch (
    .clk          (clk),
    .rst          (rst),
    .i_pixpulse   (pixpulse),
    .i_frame_end  (w_frame_end),
    .i_hit_ship   (r_hit_ship),
    .i_hit_bullet (r_hit_bullet),
    .i_hit_ast    (r_hit_ast),
`ifdef COMPOSITOR_WALL_EN
    .i_hit_wall   (r_hit_wall),
`endif
    .coll         (coll)
  );

  assign {vgaRed, vgaGreen, vgaBlue} = r_rgb;
  assign hsync = r_hs2;
  assign vsync = r_vs2;

endmodule

// File: doc/frame_compositor.md
# frame_compositor

Pixel compositor and per-frame collision reporter that sits directly downstream of the ship, score, bullet and asteroid sprite generators and upstream of the VGA pins. Each pixel it resolves the overlapping draw flags into one 12-bit colour by fixed priority and applies blanking, with a registered two-stage pipeline. It also accumulates sprite overlaps across the visible frame and hands the game logic one collision report per frame over a valid/ack handshake.

## Interface
- NUM_BULLETS, 3, number of bullet draw flags
- NUM_AST, 8, number of asteroid draw flags
- SHIP_COLOR, 12'hfd0; SCORE_COLOR, 12'hfff; BULLET_COLOR, 12'h0ff; WALL_COLOR, 12'hf00; AST_COLOR, 12'h850; EMPTY_COLOR, 12'h001
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-low reset
- pixpulse  in  1  pixel-rate enable from vga_timing
- hcount, vcount  in  10 each  current pixel coordinates
- hblank, vblank, hsync_in, vsync_in  in  1 each  timing from vga_timing
- draw_ship, draw_score  in  1 each  sprite coverage flags
- draw_bullet  in  NUM_BULLETS  per-bullet coverage
- draw_ast  in  NUM_AST  per-asteroid coverage
- vgaRed, vgaGreen, vgaBlue  out  4 each  composited colour
- hsync, vsync  out  1 each  syncs delayed to match colour
- coll_valid  out  1  report pending
- coll_ack  in  1  consumer accepts report
- ship_hit  out  1  ship overlapped an asteroid this frame
- bullet_hit  out  NUM_BULLETS  bullet overlapped an asteroid
- ast_hit  out  NUM_AST  asteroid overlapped ship or bullet
- coll_overrun  out  1  one-clk pulse: report merged before ack

## Operation
- Priority, highest first: score, ship, any bullet, any asteroid, wall (if enabled), EMPTY_COLOR.
- Stage 1 (on pixpulse): register winning colour, visible = ~hblank & ~vblank, hsync_in, vsync_in, and per-pixel hit terms.
- Stage 2 (on pixpulse): RGB = visible_d ? colour_d : 0; hsync/vsync from stage-1 copies.
- Hit terms, counted only when visible: ship&ast[j] sets ship_hit_acc, ast_hit_acc[j]; bullet[i]&ast[j] sets bullet_hit_acc[i], ast_hit_acc[j]. Accumulators are sticky OR.
- Frame end = rising edge of registered vblank (sampled on pixpulse). At frame end: accumulators copied into report outputs, accumulators cleared, coll_valid set.
- Handshake FSM, states IDLE/PENDING. IDLE: frame end -> PENDING. PENDING: coll_ack -> IDLE, report outputs hold value.
- Frame end in PENDING without ack: new hits OR-merged into report, stay PENDING, coll_overrun pulses one clk.
- Frame end and coll_ack same cycle: report replaced (not merged) by new frame, stays PENDING, no overrun.
- coll_ack in IDLE ignored.
- Report with zero hits is still issued every frame.

## Timing
- Colour and syncs: 2 pixpulse latency from inputs; all outputs updated only on pixpulse cycles except handshake logic (every clk).
- coll_valid rises one clk after the pixpulse cycle in which registered vblank rises; deasserts the clk after coll_ack sampled high.
- Reset: RGB 0, hsync/vsync 1 (inactive), coll_valid 0, all hit outputs 0, coll_overrun 0, accumulators 0, FSM IDLE.
- Reset mid-frame discards partial accumulation; first report after reset covers only the pixels after release.

## Configuration
- COMPOSITOR_WALL_EN defined: pixels with hcount in [132,137] or [408,413] draw WALL_COLOR (below asteroid priority); additional output wall_hit (1 bit) reports ship touching a wall, following same accumulate/report/merge rules.
- Undefined: no wall colour, no wall_hit port; wall region shows EMPTY_COLOR.

## Structure
- game_pkg: colour constants, NUM_BULLETS/NUM_AST defaults, wall bounds, FSM state typedef.
- One sub-module: collision_latch (accumulators, snapshot, IDLE/PENDING FSM, overrun); priority mux and sync pipeline stay in frame_compositor.

## Test plan
- draw_score and draw_ship both high on visible pixel -> RGB f/f/f two pixpulses later; ship only -> f/d/0.
- Any draw flag during hblank -> RGB 0/0/0; hsync out equals hsync_in delayed by 2 pixpulses.
- draw_bullet[1]&draw_ast[5] for one visible pixel, frame ends -> coll_valid 1, bullet_hit=3'b010, ast_hit=8'h20, ship_hit 0; ack -> coll_valid 0 next clk.
- No ack, frame 2 has ship&ast[0] -> report ast_hit=8'h21, ship_hit 1, coll_overrun single pulse.
- Ack coincident with frame end -> report equals frame 2 hits only, coll_valid stays 1, no overrun.
- Assert rst low mid-frame with hits accumulated -> all outputs to reset values immediately; next report excludes pre-reset hits.
